// File: rtl/posit_lshift_pipe.sv
// posit_lshift_pipe
// -----------------------------------------------------------------------------
// Pipelined multi-precision SIMD left shifter used on the posit extraction
// path to strip the regime field. Each segment (LANE_W << mode bits wide) is
// shifted left by (shamt + 1), zero-filled from the LSB, and never spills into
// a neighbouring segment. A segment shifted out completely yields 0 and raises
// its overflow flag on every lane it covers.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset (clears valids, data, ovf)
//   flush      synchronous flush of every in-flight transaction
//   in_valid   input transaction valid
//   in_ready   block accepts an input this cycle
//   in_data    operand, lane i = bits [i*LANE_W +: LANE_W]
//   in_mode    segment mode (0: LANE_W, 1: 2*LANE_W, 2: 4*LANE_W, ...);
//              codes beyond the legal range behave as 0
//   in_shamt   per-lane shift count, lane i = bits [i*SW +: SW]; a segment
//              uses the count of its lowest lane only
//   out_valid  result valid (registered)
//   out_ready  downstream accepts the result
//   out_data   shifted result (registered)
//   out_ovf    per-lane overflow flag (registered)
// -----------------------------------------------------------------------------
module posit_lshift_pipe #(
    parameter int W      = 32,
    parameter int LANE_W = 8,
    parameter int STAGES = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [W-1:0]                          in_data,
    input  logic [1:0]                            in_mode,
    input  logic [(W/LANE_W)*$clog2(W)-1:0]       in_shamt,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [W-1:0]                          out_data,
    output logic [W/LANE_W-1:0]                   out_ovf
);

    localparam int NL     = W / LANE_W;
    localparam int SW     = $clog2(W);
    localparam int NMODES = $clog2(NL) + 1;

    // One binary shift step of 2^k applied per segment. A bit only receives
    // data from 2^k positions below when that source lies inside the same
    // segment; otherwise it is zero-filled.
    function automatic logic [W-1:0] shift_step(
        input logic [W-1:0]     d,
        input logic [NL*SW-1:0] amt,
        input logic [1:0]       mode,
        input int               k
    );
        logic [W-1:0] r;
        int           seg;
        int           off;
        int           lane;
        r   = '0;
        seg = LANE_W << mode;
        for (int b = 0; b < W; b++) begin
            lane = b / LANE_W;
            off  = b % seg;
            if (amt[lane*SW + k]) begin
                if (off >= (1 << k)) r[b] = d[b - (1 << k)];
                else                 r[b] = 1'b0;
            end else begin
                r[b] = d[b];
            end
        end
        return r;
    endfunction

    logic             en;
    logic [1:0]       mode_n;
    logic [W-1:0]     pre_data;
    logic [NL*SW-1:0] pre_amt;
    logic [NL-1:0]    pre_ovf;

    // Global advance: the whole pipe moves unless a result is stuck at the output.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign mode_n = (32'(in_mode) < NMODES) ? in_mode : 2'd0;

    // Front end: per lane, fetch the segment's count, form eff = shamt + 1 in
    // SW+1 bits and decide overflow. Overflowing segments are zeroed up front
    // and carry a zero shift amount, so the shift network never has to handle
    // eff >= segment width.
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        int            lane_base;
        logic [SW-1:0] lane_shamt;
        logic [SW:0]   lane_eff;
        logic          lane_ovf;

        always_comb begin
            lane_base  = (gi >> mode_n) << mode_n;
            lane_shamt = in_shamt[lane_base*SW +: SW];
            lane_eff   = {1'b0, lane_shamt} + (SW+1)'(1);
            lane_ovf   = int'(lane_eff) >= (LANE_W << mode_n);
        end

        assign pre_ovf[gi]                   = lane_ovf;
        assign pre_amt[gi*SW +: SW]          = lane_ovf ? '0 : lane_eff[SW-1:0];
        assign pre_data[gi*LANE_W +: LANE_W] = lane_ovf ? '0 : in_data[gi*LANE_W +: LANE_W];
    end

    // Stage gi performs the shift steps k with (k*STAGES)/SW == gi before its
    // register, spreading the SW steps as evenly as possible.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [W-1:0]     src_data;
        logic [W-1:0]     data_next;
        logic [W-1:0]     data_reg;
        logic [NL*SW-1:0] src_amt;
        logic [1:0]       src_mode;
        logic [NL-1:0]    src_ovf;
        logic [NL-1:0]    ovf_reg;
        logic             src_valid;
        logic             valid_reg;

        if (gi == 0) begin : g_src
            assign src_data  = pre_data;
            assign src_amt   = pre_amt;
            assign src_mode  = mode_n;
            assign src_ovf   = pre_ovf;
            assign src_valid = in_valid;
        end else begin : g_src
            assign src_data  = g_stage[gi-1].data_reg;
            assign src_amt   = g_stage[gi-1].g_carry.amt_reg;
            assign src_mode  = g_stage[gi-1].g_carry.mode_reg;
            assign src_ovf   = g_stage[gi-1].ovf_reg;
            assign src_valid = g_stage[gi-1].valid_reg;
        end

        always_comb begin
            data_next = src_data;
            for (int k = 0; k < SW; k++) begin
                if ((k * STAGES) / SW == gi) data_next = shift_step(data_next, src_amt, src_mode, k);
            end
        end

        // Flush only kills valids; data may keep stale contents.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
                ovf_reg   <= '0;
            end else begin
                if (flush)   valid_reg <= 1'b0;
                else if (en) valid_reg <= src_valid;
                if (en) begin
                    data_reg <= data_next;
                    ovf_reg  <= src_ovf;
                end
            end
        end

        // Shift amounts and mode are only needed while steps remain downstream.
        if (gi < STAGES - 1) begin : g_carry
            logic [NL*SW-1:0] amt_reg;
            logic [1:0]       mode_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    amt_reg  <= '0;
                    mode_reg <= '0;
                end else if (en) begin
                    amt_reg  <= src_amt;
                    mode_reg <= src_mode;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_reg;
    assign out_data  = g_stage[STAGES-1].data_reg;
    assign out_ovf   = g_stage[STAGES-1].ovf_reg;

endmodule

// File: tb/tb_posit_lshift_pipe.sv
// Directed testbench for posit_lshift_pipe (W=32, LANE_W=8, STAGES=2).
module tb_posit_lshift_pipe;

    localparam int W      = 32;
    localparam int LANE_W = 8;
    localparam int STAGES = 2;
    localparam int NL     = W / LANE_W;
    localparam int SW     = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [1:0]       in_mode;
    logic [NL*SW-1:0] in_shamt;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [NL-1:0]    out_ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] rx_q[$];
    int           run_len = 0;
    int           max_run = 0;

    posit_lshift_pipe #(.W(W), .LANE_W(LANE_W), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .in_shamt (in_shamt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    // Output monitor: a beat seen valid&&ready at the negedge transfers at the next posedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) rx_q.push_back(out_data);
        if (out_valid) run_len = run_len + 1;
        else           run_len = 0;
        if (run_len > max_run) max_run = run_len;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Send one item into an idle pipe with out_ready=1 and wait (bounded) for its result.
    task automatic run_one(input logic [W-1:0] d, input logic [1:0] m, input logic [NL*SW-1:0] sh,
                           output logic [W-1:0] rd, output logic [NL-1:0] ro, output int lat);
        @(posedge clk); #1;
        in_data = d; in_mode = m; in_shamt = sh; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rd = '0; ro = '0; lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                rd = out_data; ro = out_ovf;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 32'h0) $display("FAIL reset_data: got %h want 00000000", out_data); else pass_cnt++;
        total_cnt++; if (out_ovf !== 4'h0) $display("FAIL reset_ovf: got %b want 0000", out_ovf); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid_after: got %b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_mode0();
        logic [W-1:0] rd; logic [NL-1:0] ro; int lat;
        run_one(32'h8142FF01, 2'd0, {5'd7, 5'd2, 5'd1, 5'd0}, rd, ro, lat);
        total_cnt++; if (rd !== 32'h0010FC02) $display("FAIL mode0_data: got %h want 0010fc02", rd); else pass_cnt++;
        total_cnt++; if (ro !== 4'b1000) $display("FAIL mode0_ovf: got %b want 1000", ro); else pass_cnt++;
        total_cnt++; if (lat !== STAGES) $display("FAIL mode0_latency: got %0d want %0d", lat, STAGES); else pass_cnt++;
        $display("mode0 item: data=%h ovf=%b latency=%0d", rd, ro, lat);
    endtask

    task automatic test_mode1();
        logic [W-1:0] rd; logic [NL-1:0] ro; int lat;
        run_one(32'h12348001, 2'd1, {5'd31, 5'd0, 5'd31, 5'd3}, rd, ro, lat);
        total_cnt++; if (rd !== 32'h24680010) $display("FAIL mode1_data: got %h want 24680010", rd); else pass_cnt++;
        total_cnt++; if (ro !== 4'b0000) $display("FAIL mode1_ovf: got %b want 0000", ro); else pass_cnt++;
        $display("mode1 item: data=%h ovf=%b", rd, ro);
    endtask

    task automatic test_mode3();
        logic [W-1:0] rd; logic [NL-1:0] ro; int lat;
        run_one(32'h8142FF01, 2'd3, {5'd7, 5'd2, 5'd1, 5'd0}, rd, ro, lat);
        total_cnt++; if (rd !== 32'h0010FC02) $display("FAIL mode3_data: got %h want 0010fc02", rd); else pass_cnt++;
        total_cnt++; if (ro !== 4'b1000) $display("FAIL mode3_ovf: got %b want 1000", ro); else pass_cnt++;
        $display("mode3 item: data=%h ovf=%b", rd, ro);
    endtask

    task automatic test_mode2();
        logic [W-1:0] rd; logic [NL-1:0] ro; int lat;
        run_one(32'h00000001, 2'd2, {5'd1, 5'd2, 5'd3, 5'd30}, rd, ro, lat);
        total_cnt++; if (rd !== 32'h80000000) $display("FAIL mode2_s30_data: got %h want 80000000", rd); else pass_cnt++;
        total_cnt++; if (ro !== 4'b0000) $display("FAIL mode2_s30_ovf: got %b want 0000", ro); else pass_cnt++;
        $display("mode2 shamt30 item: data=%h ovf=%b", rd, ro);
        run_one(32'h00000001, 2'd2, {5'd0, 5'd0, 5'd0, 5'd31}, rd, ro, lat);
        total_cnt++; if (rd !== 32'h00000000) $display("FAIL mode2_s31_data: got %h want 00000000", rd); else pass_cnt++;
        total_cnt++; if (ro !== 4'b1111) $display("FAIL mode2_s31_ovf: got %b want 1111", ro); else pass_cnt++;
        $display("mode2 shamt31 item: data=%h ovf=%b", rd, ro);
    endtask

    task automatic test_stall();
        logic [W-1:0] exp_q[3];
        logic [W-1:0] got;
        exp_q[0] = 32'h02020202; exp_q[1] = 32'h06060606; exp_q[2] = 32'h0A0A0A0A;
        @(posedge clk); #1;
        rx_q.delete();
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0; in_shamt = '0; in_data = 32'h01010101;
        @(posedge clk); #1 in_data = 32'h03030303;
        @(posedge clk); #1 in_data = 32'h05050505;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL stall_out_valid: got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== exp_q[0]) $display("FAIL stall_data: got %h want %h", out_data, exp_q[0]); else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++; if (out_data !== exp_q[0]) $display("FAIL stall_data_stable: got %h want %h", out_data, exp_q[0]); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready_held: got %b want 0", in_ready); else pass_cnt++;
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total_cnt++; if (rx_q.size() !== 3) $display("FAIL stall_count: got %0d want 3", rx_q.size()); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 32'hxxxxxxxx;
            total_cnt++; if (got !== exp_q[i]) $display("FAIL stall_order[%0d]: got %h want %h", i, got, exp_q[i]); else pass_cnt++;
            $display("stall drain item %0d: data=%h", i, got);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got;
        logic [W-1:0] exp_d;
        logic [7:0]   b;
        @(posedge clk); #1;
        rx_q.delete();
        max_run = 0;
        out_ready = 1'b1; in_mode = 2'd0; in_shamt = '0;
        for (int i = 0; i < 8; i++) begin
            b = 8'(i + 1);
            in_valid = 1'b1; in_data = {4{b}};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total_cnt++; if (max_run !== 8) $display("FAIL b2b_run: got %0d want 8", max_run); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            b = 8'((i + 1) * 2);
            exp_d = {4{b}};
            got = (i < rx_q.size()) ? rx_q[i] : 32'hxxxxxxxx;
            total_cnt++; if (got !== exp_d) $display("FAIL b2b_item[%0d]: got %h want %h", i, got, exp_d); else pass_cnt++;
            $display("b2b item %0d: data=%h", i, got);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] exp_q[4];
        logic [W-1:0] got;
        logic [7:0]   b;
        exp_q[0] = 32'h02020202; exp_q[1] = 32'h04040404; exp_q[2] = 32'h0A0A0A0A; exp_q[3] = 32'h0C0C0C0C;
        @(posedge clk); #1;
        rx_q.delete();
        out_ready = 1'b1; in_mode = 2'd0; in_shamt = '0;
        for (int i = 1; i <= 6; i++) begin
            b = 8'(i);
            in_valid = 1'b1; in_data = {4{b}}; flush = (i == 4);
            if (i == 5) begin
                @(negedge clk);
                total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", out_valid); else pass_cnt++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total_cnt++; if (rx_q.size() !== 4) $display("FAIL flush_count: got %0d want 4", rx_q.size()); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 32'hxxxxxxxx;
            total_cnt++; if (got !== exp_q[i]) $display("FAIL flush_item[%0d]: got %h want %h", i, got, exp_q[i]); else pass_cnt++;
            $display("flush survivor %0d: data=%h", i, got);
        end
    endtask

    task automatic test_reset_midflight();
        logic [W-1:0] rd; logic [NL-1:0] ro; int lat;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0;
        in_data = 32'h8142FF01; in_shamt = {5'd7, 5'd2, 5'd1, 5'd0};
        @(posedge clk); #1 in_data = 32'h01010101; in_shamt = '0;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (out_ovf !== 4'b1000) $display("FAIL rstmid_pre_ovf: got %b want 1000", out_ovf); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 32'h0) $display("FAIL rstmid_data: got %h want 00000000", out_data); else pass_cnt++;
        total_cnt++; if (out_ovf !== 4'h0) $display("FAIL rstmid_ovf: got %b want 0000", out_ovf); else pass_cnt++;
        @(posedge clk); #3 rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", in_ready); else pass_cnt++;
        rx_q.delete();
        run_one(32'h00000081, 2'd1, {5'd0, 5'd0, 5'd0, 5'd0}, rd, ro, lat);
        total_cnt++; if (rd !== 32'h00000102) $display("FAIL rstmid_next_data: got %h want 00000102", rd); else pass_cnt++;
        total_cnt++; if (lat !== STAGES) $display("FAIL rstmid_latency: got %0d want %0d", lat, STAGES); else pass_cnt++;
        $display("post-reset item: data=%h ovf=%b latency=%0d", rd, ro, lat);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0;
        in_shamt = '0; out_ready = 1'b1;
        test_reset();
        test_mode0();
        test_mode1();
        test_mode3();
        test_mode2();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/posit_lshift_pipe.md
Name: posit_lshift_pipe

Overview:
- Pipelined, multi-precision SIMD left shifter for the posit extraction path.
- Removes the regime field by shifting each segment left by (shift count + 1), with one count per lane.
- Supports 8/16/32-bit segment modes, a configurable number of pipeline stages, and valid/ready flow control.
- Reports a per-lane overflow flag when a segment is shifted out completely.
- Sits between the leading-bit counters and the exponent/fraction split.

Parameters:
- W, 32, total datapath width; a power of two, and a multiple of LANE_W.
- LANE_W, 8, width of the narrowest segment (lane); NL = W/LANE_W lanes.
- STAGES, 2, number of register stages (1..SW), where SW = clog2(W).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous flush; clears all in-flight transactions.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  W  operand; lane i = bits [i*LANE_W +: LANE_W].
- in_mode  in  2  segment mode: 0 = LANE_W, 1 = 2*LANE_W, 2 = 4*LANE_W (capped at W); codes >= number of legal modes act as 0.
- in_shamt  in  NL*SW  per-lane shift count; lane i = bits [i*SW +: SW].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W  shifted result.
- out_ovf  out  NL  per-lane overflow flag; replicated across all lanes of a segment.

Behaviour:
- Segments:
  - Segment width SEG = LANE_W << mode.
  - Segment j covers bits [j*SEG +: SEG].
  - Each segment uses the shamt of its lowest-indexed lane. Other lanes' shamt values are ignored.
- Arithmetic:
  - eff = shamt + 1, computed in SW+1 bits, so there is no wrap at shamt = 2^SW - 1.
  - Result = segment << eff, truncated to SEG bits, zero-filled from the LSB.
  - Bits never cross segment boundaries.
  - If eff >= SEG: the segment result is 0 and ovf = 1 for every lane of that segment; otherwise ovf = 0.
- Mode, shamt and data are captured together and travel down the pipe with the transaction. Changing in_mode does not affect in-flight items.
- Pipelining:
  - The SW binary shift steps (1, 2, 4, ...) are split as evenly as possible across STAGES register stages.
  - The eff/ovf computation is done before the first register.
  - The last stage register drives out_data, out_ovf and out_valid directly (registered outputs).
- Latency: an input accepted at clock edge t appears with out_valid = 1 after edge t + STAGES - 1, i.e. STAGES cycles of latency with no stall.
- Handshake:
  - Global advance enable: en = !out_valid || out_ready; in_ready = en.
  - An input transfers when in_valid && in_ready.
  - When en = 1, every stage loads from its predecessor. A stage 1 load without an input transfer inserts a bubble (valid = 0).
  - Bubbles are not collapsed.
  - When en = 0, all stages hold.
  - Data and ovf must stay stable while out_valid && !out_ready.
  - Order is preserved; there is no loss and no duplication.
- Throughput: 1 transaction/cycle when out_ready is held high.
- Flush:
  - On the edge where flush = 1, all stage valids clear to 0, regardless of en.
  - An input presented in that same cycle is dropped. in_ready may still read 1, but flush wins.
  - Data registers may keep stale values.
- Reset:
  - rst = 1 immediately clears all stage valids, data and ovf registers to 0.
  - Thus out_valid = 0, out_data = 0, out_ovf = 0, and in_ready = 1 once reset is released.
  - Reset mid-transaction discards all in-flight items.
- Simultaneous out accept and in accept in the same cycle is legal and keeps full throughput.

Test Plan:
- W=32, mode=0, in_data=0x8142FF01, lane shamt[0..3]=0,1,2,7 -> out_data=0x0010FC02, out_ovf=4'b1000, out_valid STAGES cycles after accept.
- mode=1, in_data=0x12348001, shamt lane0=3, lane2=0, lanes1/3=31 (ignored) -> out_data=0x24680010, out_ovf=4'b0000. mode=3 with the mode-0 vector gives the mode-0 result.
- mode=2, in_data=0x00000001: shamt=30 -> out_data=0x80000000, ovf=4'b0000; shamt=31 -> out_data=0, ovf=4'b1111 (no wrap).
- STAGES=2, out_ready held 0, in_valid held 1 with items A,B,C -> only A,B accepted and in_ready drops to 0 with out_data=A stable. Raising out_ready then yields A,B,C in order, one per cycle.
- Streaming 8 back-to-back items with out_ready=1 -> 8 consecutive out_valid cycles. Flush asserted mid-stream -> out_valid=0 on the next cycle and flushed items never appear.
- rst pulsed asynchronously (between clock edges) while 2 items are in flight -> out_valid, out_data, out_ovf = 0 immediately. After release, in_ready = 1 and the next item has full latency.
